mesh_router_wh: RTL and testbench

Five-port wormhole router for 2D mesh NoC tiles. It is the successor to the single-flit XY router: it adds multi-flit packets with output locking, a build-time XY/YX routing mode and round-robin output allocation. Each input has a buffer. One instance sits at each mesh node, with port 0 attached to the local endpoint and ports 1-4 wired to the neighbouring routers.

---
 rtl/mesh_router_wh.sv | 149 ++++++++++++++
 tb/tb_mesh_router_wh.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_router_wh.sv
// Five-port wormhole mesh router: one FIFO per input, XY/YX route compute on the
// head flit, and per-output locks granted round-robin and held until the tail pops.
module mesh_router_wh #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int X_WIDTH    = 2,
    parameter int Y_WIDTH    = 2,
    parameter int SOURCE_X   = 0,
    parameter int SOURCE_Y   = 0,
    parameter int ROUTE_YX   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i [5],
    input  logic [4:0]            last_i,
    input  logic [4:0]            valid_i,
    output logic [4:0]            ready_o,
    output logic [DATA_WIDTH-1:0] data_o [5],
    output logic [4:0]            last_o,
    output logic [4:0]            valid_o,
    input  logic [4:0]            ready_i
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [4:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0][CNT_W-1:0] count_q, count_d;
    logic [4:0]            bound_q, bound_d;
    logic [4:0]            lock_q, lock_d;
    logic [4:0][2:0]       owner_q, owner_d;
    logic [4:0][2:0]       rr_q, rr_d;

    logic [4:0][DATA_WIDTH:0] head;
    logic [4:0]               fifo_empty, push, pop, out_pop, req_valid;
    logic [4:0][2:0]          req_port;

    function automatic logic [2:0] route_port(input logic [DATA_WIDTH:0] flit);
        logic [X_WIDTH-1:0] dx;
        logic [Y_WIDTH-1:0] dy;
        logic [2:0]         px, py;
        dx = flit[X_WIDTH-1:0];
        dy = flit[X_WIDTH+Y_WIDTH-1:X_WIDTH];
        px = (int'(dx) > SOURCE_X) ? 3'd2 : ((int'(dx) < SOURCE_X) ? 3'd4 : 3'd0);
        py = (int'(dy) > SOURCE_Y) ? 3'd3 : ((int'(dy) < SOURCE_Y) ? 3'd1 : 3'd0);
        if (ROUTE_YX != 0) begin
            return (py != 3'd0) ? py : px;
        end
        return (px != 3'd0) ? px : py;
    endfunction

    for (genvar gi = 0; gi < 5; gi++) begin : g_in
        logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

        always_ff @(posedge clk_i) begin
            if (push[gi]) begin
                mem[wr_ptr_q[gi]] <= {last_i[gi], data_i[gi]};
            end
        end

        assign head[gi]       = mem[rd_ptr_q[gi]];
        assign fifo_empty[gi] = (count_q[gi] == '0);
        assign ready_o[gi]    = !rst_i && (count_q[gi] != FULL_CNT);
        assign push[gi]       = valid_i[gi] && ready_o[gi];
        // An idle input's head is always a header, so it requests its routed output.
        assign req_valid[gi]  = !bound_q[gi] && !fifo_empty[gi];
        assign req_port[gi]   = route_port(head[gi]);
    end

    always_comb begin
        pop     = '0;
        out_pop = '0;
        valid_o = '0;
        last_o  = '0;
        for (int o = 0; o < 5; o++) begin
            data_o[o] = '0;
            if (!rst_i && lock_q[o] && !fifo_empty[owner_q[o]]) begin
                valid_o[o] = 1'b1;
                data_o[o]  = head[owner_q[o]][DATA_WIDTH-1:0];
                last_o[o]  = head[owner_q[o]][DATA_WIDTH];
                out_pop[o] = ready_i[o];
                if (ready_i[o]) begin
                    pop[owner_q[o]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bound_d  = bound_q;
        lock_d   = lock_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        for (int i = 0; i < 5; i++) begin
            if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
        for (int o = 0; o < 5; o++) begin
            if (lock_q[o]) begin
                // A released output sits out this edge; it is re-allocated next edge at the earliest.
                if (out_pop[o] && head[owner_q[o]][DATA_WIDTH]) begin
                    lock_d[o]            = 1'b0;
                    bound_d[owner_q[o]]  = 1'b0;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    idx = int'(rr_q[o]) + k;
                    if (idx >= 5) idx = idx - 5;
                    if (!found && req_valid[idx] && (req_port[idx] == 3'(o))) begin
                        found      = 1'b1;
                        lock_d[o]  = 1'b1;
                        owner_d[o] = 3'(idx);
                        bound_d[idx] = 1'b1;
                        rr_d[o]    = (idx == 4) ? 3'd0 : 3'(idx + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bound_q  <= '0;
            lock_q   <= '0;
            owner_q  <= '0;
            rr_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bound_q  <= bound_d;
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
        end
    end
endmodule

// File: tb/tb_mesh_router_wh.sv
// Bench for mesh_router_wh at node (1,1): an XY and a YX instance share stimulus and
// are both checked every cycle against a queue-based packet model.
module tb_mesh_router_wh;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] din [5];
    logic [4:0]    lin, vin, rdy_in;
    logic [DW-1:0] dout_a [5];
    logic [DW-1:0] dout_b [5];
    logic [4:0]    rdy_a, rdy_b, lout_a, lout_b, vout_a, vout_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW:0]   mq [10][$];
    bit            mlock  [10];
    int            mown   [10];
    int            mrr    [10];
    bit            mbound [10];
    logic [DW-1:0] seen [5][$];
    int            seen_cyc [5][$];

    mesh_router_wh #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .X_WIDTH(2), .Y_WIDTH(2),
                     .SOURCE_X(1), .SOURCE_Y(1), .ROUTE_YX(0)) dut_xy (
        .clk_i(clk), .rst_i(rst), .data_i(din), .last_i(lin), .valid_i(vin),
        .ready_o(rdy_a), .data_o(dout_a), .last_o(lout_a), .valid_o(vout_a), .ready_i(rdy_in));

    mesh_router_wh #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .X_WIDTH(2), .Y_WIDTH(2),
                     .SOURCE_X(1), .SOURCE_Y(1), .ROUTE_YX(1)) dut_yx (
        .clk_i(clk), .rst_i(rst), .data_i(din), .last_i(lin), .valid_i(vin),
        .ready_o(rdy_b), .data_o(dout_b), .last_o(lout_b), .valid_o(vout_b), .ready_i(rdy_in));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Output port chosen by the node at (1,1) for a header; yx selects y-first order.
    function automatic int exp_port(int yx, logic [DW:0] f);
        int dx, dy;
        dx = int'(f[1:0]);
        dy = int'(f[3:2]);
        if (yx != 0 && dy != 1) return (dy > 1) ? 3 : 1;
        if (dx != 1) return (dx > 1) ? 2 : 4;
        if (dy != 1) return (dy > 1) ? 3 : 1;
        return 0;
    endfunction

    function automatic logic [DW-1:0] hdr(int x, int y, int tag);
        return DW'((tag << 4) | (y << 2) | x);
    endfunction

    function automatic logic [DW-1:0] body(int tag);
        return DW'(tag << 4);
    endfunction

    task automatic compare_inst(int m);
        logic [4:0]    v, l, r;
        logic [DW-1:0] d [5];
        string         nm;
        nm = (m != 0) ? "yx" : "xy";
        v  = (m != 0) ? vout_b : vout_a;
        l  = (m != 0) ? lout_b : lout_a;
        r  = (m != 0) ? rdy_b  : rdy_a;
        for (int p = 0; p < 5; p++) d[p] = (m != 0) ? dout_b[p] : dout_a[p];
        for (int p = 0; p < 5; p++) begin
            logic        er, ev;
            logic [DW:0] f;
            int          own;
            own = mown[m*5+p];
            er  = !rst && (mq[m*5+p].size() < DEPTH);
            ev  = !rst && mlock[m*5+p] && (mq[m*5+own].size() > 0);
            f   = ev ? mq[m*5+own][0] : '0;
            chk($sformatf("%s.ready[%0d]", nm, p), 64'(r[p]), 64'(er));
            chk($sformatf("%s.valid[%0d]", nm, p), 64'(v[p]), 64'(ev));
            chk($sformatf("%s.data[%0d]",  nm, p), 64'(d[p]), 64'(f[DW-1:0]));
            chk($sformatf("%s.last[%0d]",  nm, p), 64'(l[p]), 64'(f[DW]));
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int gw [5];
            int sz [5];
            if (rst) begin
                for (int i = 0; i < 5; i++) begin
                    mq[m*5+i].delete();
                    mlock[m*5+i] = 0; mown[m*5+i] = 0; mrr[m*5+i] = 0; mbound[m*5+i] = 0;
                end
            end else begin
                for (int i = 0; i < 5; i++) sz[i] = mq[m*5+i].size();
                for (int o = 0; o < 5; o++) begin
                    gw[o] = -1;
                    if (!mlock[m*5+o]) begin
                        for (int k = 0; k < 5; k++) begin
                            int i;
                            i = (mrr[m*5+o] + k) % 5;
                            if (gw[o] < 0 && !mbound[m*5+i] && sz[i] > 0 &&
                                exp_port(m, mq[m*5+i][0]) == o) gw[o] = i;
                        end
                    end
                end
                for (int o = 0; o < 5; o++) begin
                    if (mlock[m*5+o]) begin
                        int own;
                        own = mown[m*5+o];
                        if (mq[m*5+own].size() > 0 && rdy_in[o]) begin
                            logic [DW:0] f;
                            f = mq[m*5+own].pop_front();
                            if (f[DW]) begin
                                mlock[m*5+o]    = 0;
                                mbound[m*5+own] = 0;
                            end
                        end
                    end
                end
                for (int o = 0; o < 5; o++) begin
                    if (gw[o] >= 0) begin
                        mlock[m*5+o]      = 1;
                        mown[m*5+o]       = gw[o];
                        mbound[m*5+gw[o]] = 1;
                        mrr[m*5+o]        = (gw[o] + 1) % 5;
                    end
                end
                for (int i = 0; i < 5; i++) begin
                    if (vin[i] && sz[i] < DEPTH) mq[m*5+i].push_back({lin[i], din[i]});
                end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            compare_inst(0);
            compare_inst(1);
            for (int o = 0; o < 5; o++) begin
                if (vout_a[o] && rdy_in[o]) begin
                    seen[o].push_back(dout_a[o]);
                    seen_cyc[o].push_back(cyc);
                end
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_seen();
        for (int p = 0; p < 5; p++) begin
            seen[p].delete();
            seen_cyc[p].delete();
        end
    endtask

    task automatic drive(int p, logic [DW-1:0] d, logic l);
        din[p] = d;
        lin[p] = l;
        vin[p] = 1'b1;
    endtask

    initial begin
        int exp_rr  [6] = '{'h10, 'h20, 'h30, 'h11, 'h21, 'h31};
        int exp_pkt [7] = '{'h40, 'h41, 'h42, 'h43, 'h50, 'h51, 'h52};
        int accepted, stall, attempts;
        rst = 1'b1; vin = '0; lin = '0; rdy_in = 5'b11111;
        for (int p = 0; p < 5; p++) din[p] = '0;
        tick(); tick();
        chk("rst.valid_xy", 64'(vout_a), 64'h0);
        chk("rst.ready_xy", 64'(rdy_a), 64'h0);
        chk("rst.ready_yx", 64'(rdy_b), 64'h0);
        rst = 1'b0;
        tick();
        chk("rst.ready_after", 64'(rdy_a), 64'h1f);

        // Single-flit header to (3,0): east in XY, north in YX, two cycles after the push.
        drive(0, hdr(3, 0, 'hA1), 1'b1);
        tick(); vin = '0;
        chk("single.early_xy", 64'(vout_a), 64'h0);
        tick();
        chk("single.valid_xy", 64'(vout_a), 64'h04);
        chk("single.data_xy", 64'(dout_a[2]), 64'hA13);
        chk("single.last_xy", 64'(lout_a[2]), 64'h1);
        chk("single.valid_yx", 64'(vout_b), 64'h02);
        chk("single.data_yx", 64'(dout_b[1]), 64'hA13);
        tick();
        chk("single.done_xy", 64'(vout_a), 64'h0);
        repeat (2) tick();

        // Round-robin on the local output: ports 1..3, two single-flit packets each.
        clear_seen();
        for (int s = 0; s < 2; s++) begin
            for (int p = 1; p <= 3; p++) drive(p, hdr(1, 1, p * 16 + s), 1'b1);
            tick();
        end
        vin = '0;
        repeat (20) tick();
        chk("rr.count", 64'(seen[0].size()), 64'd6);
        for (int k = 0; k < 6; k++)
            if (k < seen[0].size()) chk($sformatf("rr.order[%0d]", k), 64'(seen[0][k] >> 4), 64'(exp_rr[k]));

        // 4-flit packet port 4 -> local, concurrent 3-flit packet port 2 -> local.
        clear_seen();
        drive(4, hdr(1, 1, 'h40), 1'b0); tick();
        drive(4, body('h41), 1'b0); drive(2, hdr(1, 1, 'h50), 1'b0); tick();
        drive(4, body('h42), 1'b0); drive(2, body('h51), 1'b0); tick();
        drive(4, body('h43), 1'b1); drive(2, body('h52), 1'b1); tick();
        vin = '0;
        repeat (12) tick();
        chk("pkt.count", 64'(seen[0].size()), 64'd7);
        for (int k = 0; k < 7; k++)
            if (k < seen[0].size()) chk($sformatf("pkt.order[%0d]", k), 64'(seen[0][k] >> 4), 64'(exp_pkt[k]));
        if (seen[0].size() == 7) begin
            chk("pkt.stream", 64'(seen_cyc[0][3] - seen_cyc[0][0]), 64'd3);
            chk("pkt.gap", 64'((seen_cyc[0][4] - seen_cyc[0][3]) >= 2), 64'd1);
        end

        // Backpressure: six flits to (2,1) with the east output stalled.
        clear_seen();
        rdy_in[2] = 1'b0; accepted = 0; stall = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, (k == 0) ? hdr(2, 1, 'h60) : body('h60 + k), k == 5);
            attempts = 0;
            while (!rdy_a[0] && attempts < 20) begin
                attempts++; stall++;
                if (stall == 1) chk("full.accepted_before_stall", 64'(accepted), 64'd4);
                if (stall == 3) rdy_in[2] = 1'b1;
                tick();
            end
            if (attempts >= 20) chk("full.timeout", 64'd1, 64'd0);
            tick();
            accepted++;
        end
        vin = '0;
        chk("full.stalled", 64'(stall > 0), 64'd1);
        repeat (10) tick();
        chk("full.count", 64'(seen[2].size()), 64'd6);
        for (int k = 0; k < 6; k++)
            if (k < seen[2].size()) chk($sformatf("full.order[%0d]", k), 64'(seen[2][k] >> 4), 64'('h60 + k));

        // Reset while flit 2 of a 4-flit packet is in flight, then a fresh packet.
        clear_seen();
        drive(0, hdr(3, 0, 'h70), 1'b0); tick();
        drive(0, body('h71), 1'b0); tick();
        chk("midrst.active", 64'(vout_a), 64'h04);
        vin = '0; rst = 1'b1;
        tick();
        chk("midrst.valid_xy", 64'(vout_a), 64'h0);
        chk("midrst.valid_yx", 64'(vout_b), 64'h0);
        tick(); rst = 1'b0;
        tick();
        chk("midrst.ready_after", 64'(rdy_a), 64'h1f);
        drive(3, hdr(1, 0, 'h80), 1'b1); tick();
        vin = '0;
        repeat (6) tick();
        chk("midrst.new_count", 64'(seen[1].size()), 64'd1);
        if (seen[1].size() > 0) chk("midrst.new_tag", 64'(seen[1][0] >> 4), 64'h80);
        chk("midrst.no_stale", 64'(seen[2].size()), 64'd0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
